// File: rtl/aes128_key_expand.sv
// AES-128 key schedule generator (FIPS-197 key expansion).
// Builds one round key per clock from a latched cipher key and keeps the full
// 11-key bundle stable until the next accepted start.
// Round key r sits at o_Key[1407-128r -: 128], so round key 0 occupies the top slot.
module aes128_key_expand #(
  parameter int NR = 10
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic [127:0]          i_Key,
  input  logic                  i_fStart,
  output logic [128*(NR+1)-1:0] o_Key,
  output logic                  o_fBusy,
  output logic                  o_fDone,
  output logic                  o_fKeyValid
);

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] w;
  logic [127:0] w_next;
  logic [31:0]  rot_word;
  logic [31:0]  t;
  logic [31:0]  n0;
  logic [31:0]  n1;
  logic [31:0]  n2;
  logic [31:0]  n3;

  // Byte a is stored at bit offset 8*(255-a), which is {~a, 3'b000}.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    logic [10:0] lo;
    lo = {~b, 3'b000};
    return SBOX[lo +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One round of the schedule: derive the next four words from the current ones.
  always_comb begin
    rot_word = {w[23:0], w[31:24]};
    t        = sub_word(rot_word) ^ {rcon, 24'h000000};
    n0       = w[127:96] ^ t;
    n1       = w[95:64]  ^ n0;
    n2       = w[63:32]  ^ n1;
    n3       = w[31:0]   ^ n2;
    w_next   = {n0, n1, n2, n3};
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; busy and done are decoded straight from the state.
  always_comb begin
    state_next = state;
    o_fBusy    = 1'b0;
    o_fDone    = 1'b0;
    case (state)
      IDLE: begin
        if (i_fStart) begin
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        o_fBusy = 1'b1;
        if (round == LAST_ROUND) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_fDone    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch the key on start, then write one round-key slot per clock.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      round       <= 4'd0;
      rcon        <= 8'h01;
      w           <= '0;
      o_Key       <= '0;
      o_fKeyValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_fStart) begin
            o_Key[128*NR +: 128] <= i_Key;
            w                    <= i_Key;
            round                <= 4'd1;
            rcon                 <= 8'h01;
            o_fKeyValid          <= 1'b0;
          end
        end
        EXPAND: begin
          w    <= w_next;
          rcon <= xtime(rcon);
          for (int r = 1; r <= NR; r++) begin
            if (round == 4'(r)) begin
              o_Key[128*(NR-r) +: 128] <= w_next;
            end
          end
          if (round == LAST_ROUND) begin
            round       <= 4'd0;
            o_fKeyValid <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: begin
          round <= round;
        end
      endcase
    end
  end

endmodule
